// File: rtl/pio_wmem_nw_pkg.sv
// pio_wmem_nw_pkg: shared types and sizing helpers for the wide-entry PIO
// memory window.
//   pio_op_e : decoded kind of an accepted PIO access
//   calc_nw  : 32-bit PIO words needed to cover one entry
//   calc_sw  : word-select bits needed to address those words
// The PIO bus constants normally come from the shared defines.vh. The guarded
// block below supplies the standard values only when that header has not
// already been read ahead of this file.
`ifndef PIO_NBITS
`define PIO_NBITS 32
`endif
`ifndef PIO_RANGE
`define PIO_RANGE 31:0
`endif
`ifndef PIO_ADDR_MSB
`define PIO_ADDR_MSB 15
`endif

package pio_wmem_nw_pkg;

    typedef enum logic [2:0] {
        PIO_IDLE,    // nothing accepted this clk
        PIO_STAGE,   // write to a low word: park it in the stage register
        PIO_COMMIT,  // write to the top word: write the whole entry
        PIO_WR_NOP,  // write beyond the entry: ack only
        PIO_RD_RAM,  // read of word 0: fetch the entry into capture
        PIO_RD_CAP,  // read of a higher word: serve it from capture
        PIO_RD_ZERO  // read beyond the entry: return 0
    } pio_op_e;

    function automatic int calc_nw(input int width);
        return (width + `PIO_NBITS - 1) / `PIO_NBITS;
    endfunction

    function automatic int calc_sw(input int nw);
        return (nw <= 1) ? 1 : $clog2(nw);
    endfunction

endpackage

// File: rtl/pio_wmem_nw_ram_1r1w.sv
// ram_1r1w: simple dual-port RAM, one read port and one write port on the same
// clock. The read is registered, so data appears one clk after rd_en. A read and
// a write to the same address in the same clk return the old contents.
//   rd_en/raddr -> rdata (1 clk later, held until the next rd_en)
//   wr_en/waddr/wdata   : write port
module ram_1r1w #(
    parameter int WIDTH       = 100,
    parameter int DEPTH_NBITS = 10
) (
    input  logic                   clk,
    input  logic                   rd_en,
    input  logic [DEPTH_NBITS-1:0] raddr,
    output logic [WIDTH-1:0]       rdata,
    input  logic                   wr_en,
    input  logic [DEPTH_NBITS-1:0] waddr,
    input  logic [WIDTH-1:0]       wdata
);
    logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_NBITS)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rd_en) rdata_q <= mem_q[raddr];
        if (wr_en) mem_q[waddr] <= wdata;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pio_wmem_nw.sv
// pio_wmem_nw: a memory of WIDTH-bit entries shared between a 32-bit PIO port
// and a full-width application port.
// PIO side (clk_div is the PIO clock-enable):
//   reg_addr/reg_din/reg_rd/reg_wr/reg_ms in, mem_ack/mem_rdata out.
//   Each entry occupies 2^SW dwords. Writes to the low words are staged; the
//   write to the top word commits the whole entry. A read of word 0 fetches the
//   entry into a capture register; reads of higher words are served from it.
// App side (full throughput, has priority over PIO on both RAM ports):
//   app_mem_rd/app_mem_raddr -> app_mem_ack/app_mem_rdata two clks later.
//   app_mem_wr/app_mem_waddr/app_mem_wdata write directly.
module pio_wmem_nw
    import pio_wmem_nw_pkg::*;
#(
    parameter int WIDTH       = 100,
    parameter int DEPTH_NBITS = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_div,
    input  logic [`PIO_RANGE]      reg_addr,
    input  logic [`PIO_RANGE]      reg_din,
    input  logic                   reg_rd,
    input  logic                   reg_wr,
    input  logic                   reg_ms,
    output logic                   mem_ack,
    output logic [`PIO_RANGE]      mem_rdata,
    input  logic                   app_mem_rd,
    input  logic [DEPTH_NBITS-1:0] app_mem_raddr,
    output logic                   app_mem_ack,
    output logic [WIDTH-1:0]       app_mem_rdata,
    input  logic                   app_mem_wr,
    input  logic [DEPTH_NBITS-1:0] app_mem_waddr,
    input  logic [WIDTH-1:0]       app_mem_wdata
);
    localparam int PW     = `PIO_NBITS;
    localparam int NW     = calc_nw(WIDTH);
    localparam int SW     = calc_sw(NW);
    localparam int CW     = NW * PW;
    localparam int STAGES = 2;   // app read: RAM register + output register

    // ---------------- address decode ----------------
    logic [`PIO_ADDR_MSB-2:0] dword;
    logic [SW-1:0]            k;
    logic [31:0]              k_w;
    logic [DEPTH_NBITS-1:0]   entry;

    assign dword = reg_addr[`PIO_ADDR_MSB:2];
    assign k     = dword[SW-1:0];
    assign k_w   = 32'(k);
    assign entry = dword[SW+DEPTH_NBITS-1:SW];

    // ---------------- state ----------------
    logic                    mem_ack_q, mem_ack_d;
    logic                    done_q, done_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    rd_wait_q, rd_wait_d;   // PIO RAM read in flight
    logic [STAGES:1]         vld_pipe_q, vld_pipe_d;
    logic [DEPTH_NBITS-1:0]  rd_entry_q, rd_entry_d;
    logic [DEPTH_NBITS-1:0]  wr_entry_q, wr_entry_d;
    logic [WIDTH-1:0]        wr_data_q, wr_data_d;
    logic [NW-2:0][PW-1:0]   stage_q, stage_d;
    logic [NW-1:0][PW-1:0]   capture_q, capture_d;
    logic [PW-1:0]           mem_rdata_q, mem_rdata_d;
    logic [WIDTH-1:0]        app_mem_rdata_q, app_mem_rdata_d;

    // ---------------- RAM port signals ----------------
    logic                   ram_rd_en, ram_wr_en;
    logic [DEPTH_NBITS-1:0] ram_raddr, ram_waddr;
    logic [WIDTH-1:0]       ram_wdata, ram_rdata;

    // Commit image: the incoming top word above the staged low words; bits
    // beyond WIDTH are dropped.
    logic [CW-1:0]    full_wdata;
    logic [WIDTH-1:0] commit_data;
    assign full_wdata  = {reg_din, stage_q};
    assign commit_data = full_wdata[WIDTH-1:0];

    logic unused_ok;
    assign unused_ok = ^{reg_addr, dword, full_wdata};

    // The master is single-outstanding, so nothing new is taken while an
    // access is still being completed or acknowledged.
    logic    busy;
    pio_op_e op;
    assign busy = done_q | rd_pend_q | wr_pend_q | rd_wait_q;

    always_comb begin
        op = PIO_IDLE;
        if (!rst && clk_div && reg_ms && !busy) begin
            if (reg_wr) begin
                if (k_w < NW - 1)       op = PIO_STAGE;
                else if (k_w == NW - 1) op = PIO_COMMIT;
                else                    op = PIO_WR_NOP;
            end else if (reg_rd) begin
                if (k_w == 0)           op = PIO_RD_RAM;
                else if (k_w < NW)      op = PIO_RD_CAP;
                else                    op = PIO_RD_ZERO;
            end
        end
    end

    logic [PW-1:0] cap_word;
    always_comb begin
        cap_word = '0;
        for (int i = 0; i < NW; i++)
            if (k_w == 32'(i)) cap_word = capture_q[i];
    end

    logic evt;
    always_comb begin
        done_d          = done_q;
        rd_pend_d       = rd_pend_q;
        wr_pend_d       = wr_pend_q;
        rd_wait_d       = 1'b0;
        rd_entry_d      = rd_entry_q;
        wr_entry_d      = wr_entry_q;
        wr_data_d       = wr_data_q;
        stage_d         = stage_q;
        capture_d       = capture_q;
        mem_rdata_d     = mem_rdata_q;
        mem_ack_d       = mem_ack_q;
        app_mem_rdata_d = app_mem_rdata_q;
        vld_pipe_d      = {vld_pipe_q[STAGES-1:1], app_mem_rd};
        ram_rd_en       = app_mem_rd;
        ram_raddr       = app_mem_raddr;
        ram_wr_en       = app_mem_wr;
        ram_waddr       = app_mem_waddr;
        ram_wdata       = app_mem_wdata;
        evt             = 1'b0;

        case (op)
            PIO_STAGE: begin
                for (int i = 0; i < NW - 1; i++)
                    if (k_w == 32'(i)) stage_d[i] = reg_din;
                evt = 1'b1;
            end
            PIO_COMMIT: begin
                if (app_mem_wr) begin
                    wr_pend_d  = 1'b1;
                    wr_entry_d = entry;
                    wr_data_d  = commit_data;
                end else begin
                    ram_wr_en = 1'b1;
                    ram_waddr = entry;
                    ram_wdata = commit_data;
                    evt       = 1'b1;
                end
            end
            PIO_RD_RAM: begin
                if (app_mem_rd) begin
                    rd_pend_d  = 1'b1;
                    rd_entry_d = entry;
                end else begin
                    ram_rd_en = 1'b1;
                    ram_raddr = entry;
                    rd_wait_d = 1'b1;
                end
            end
            PIO_RD_CAP: begin
                mem_rdata_d = cap_word;
                evt         = 1'b1;
            end
            PIO_RD_ZERO: begin
                mem_rdata_d = '0;
                evt         = 1'b1;
            end
            PIO_WR_NOP: evt = 1'b1;
            default: ;
        endcase

        // Deferred PIO accesses retire on the first clk the app leaves the
        // port free; held off during reset so a discarded commit never lands.
        if (wr_pend_q && !app_mem_wr && !rst) begin
            ram_wr_en = 1'b1;
            ram_waddr = wr_entry_q;
            ram_wdata = wr_data_q;
            wr_pend_d = 1'b0;
            evt       = 1'b1;
        end
        if (rd_pend_q && !app_mem_rd && !rst) begin
            ram_rd_en = 1'b1;
            ram_raddr = rd_entry_q;
            rd_pend_d = 1'b0;
            rd_wait_d = 1'b1;
        end
        if (rd_wait_q) begin
            capture_d   = CW'(ram_rdata);
            mem_rdata_d = ram_rdata[PW-1:0];
            evt         = 1'b1;
        end

        if (vld_pipe_q[1]) app_mem_rdata_d = ram_rdata;

        // done bridges from the completion clk to the next clk_div boundary,
        // where mem_ack picks it up for one full clk_div period.
        if (evt)          done_d = 1'b1;
        else if (clk_div) done_d = 1'b0;
        if (clk_div)      mem_ack_d = done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ack_q  <= 1'b0;
            done_q     <= 1'b0;
            rd_pend_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            rd_wait_q  <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            mem_ack_q  <= mem_ack_d;
            done_q     <= done_d;
            rd_pend_q  <= rd_pend_d;
            wr_pend_q  <= wr_pend_d;
            rd_wait_q  <= rd_wait_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    // Datapath registers carry no reset.
    always_ff @(posedge clk) begin
        rd_entry_q      <= rd_entry_d;
        wr_entry_q      <= wr_entry_d;
        wr_data_q       <= wr_data_d;
        stage_q         <= stage_d;
        capture_q       <= capture_d;
        mem_rdata_q     <= mem_rdata_d;
        app_mem_rdata_q <= app_mem_rdata_d;
    end

    ram_1r1w #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS)) u_ram (
        .clk   (clk),
        .rd_en (ram_rd_en),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .wr_en (ram_wr_en),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    assign mem_ack       = mem_ack_q;
    assign mem_rdata     = mem_rdata_q;
    assign app_mem_ack   = vld_pipe_q[STAGES];
    assign app_mem_rdata = app_mem_rdata_q;
endmodule

// File: tb/tb_pio_wmem_nw.sv
// tb_pio_wmem_nw: directed bench. dut is the default 100-bit configuration
// (4 words, 16-byte stride); dut2 is 160 bits (5 words, 32-byte stride) so
// that word indices beyond the entry exist.
module tb_pio_wmem_nw;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_div = 1'b1;
    logic [31:0] reg_addr = '0, reg_din = '0;
    logic        reg_rd = 1'b0, reg_wr = 1'b0, reg_ms = 1'b0, reg_ms2 = 1'b0;

    logic        mem_ack, app_mem_ack;
    logic [31:0] mem_rdata;
    logic        app_mem_rd = 1'b0, app_mem_wr = 1'b0;
    logic [9:0]  app_mem_raddr = '0, app_mem_waddr = '0;
    logic [99:0] app_mem_rdata, app_mem_wdata = '0;

    logic         mem_ack2, app_mem_ack2;
    logic [31:0]  mem_rdata2;
    logic         app_mem_rd2 = 1'b0, app_mem_wr2 = 1'b0;
    logic [3:0]   app_mem_raddr2 = '0, app_mem_waddr2 = '0;
    logic [159:0] app_mem_rdata2, app_mem_wdata2 = '0;

    int  n_run = 0, n_fail = 0;
    bit  sel2 = 1'b0;
    bit  div4 = 1'b0;
    logic        cur_ack;
    logic [31:0] cur_rdata;
    assign cur_ack   = sel2 ? mem_ack2 : mem_ack;
    assign cur_rdata = sel2 ? mem_rdata2 : mem_rdata;

    pio_wmem_nw #(.WIDTH(100), .DEPTH_NBITS(10)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .app_mem_rd(app_mem_rd), .app_mem_raddr(app_mem_raddr),
        .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
        .app_mem_wr(app_mem_wr), .app_mem_waddr(app_mem_waddr), .app_mem_wdata(app_mem_wdata));

    pio_wmem_nw #(.WIDTH(160), .DEPTH_NBITS(4)) dut2 (
        .clk(clk), .rst(rst), .clk_div(clk_div),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr), .reg_ms(reg_ms2),
        .mem_ack(mem_ack2), .mem_rdata(mem_rdata2),
        .app_mem_rd(app_mem_rd2), .app_mem_raddr(app_mem_raddr2),
        .app_mem_ack(app_mem_ack2), .app_mem_rdata(app_mem_rdata2),
        .app_mem_wr(app_mem_wr2), .app_mem_waddr(app_mem_waddr2), .app_mem_wdata(app_mem_wdata2));

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // clk_div: every clk normally, every 4th clk when div4 is set.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (div4) begin
                cnt = (cnt + 1) % 4;
                clk_div = (cnt == 0);
            end else begin
                cnt = 0;
                clk_div = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; strobes are held for one clk.
    task automatic pio_issue(input bit wr, input logic [31:0] addr, input logic [31:0] din);
        reg_addr = addr; reg_din = din; reg_wr = wr; reg_rd = !wr;
        if (sel2) reg_ms2 = 1'b1; else reg_ms = 1'b1;
        @(negedge clk);
        reg_wr = 1'b0; reg_rd = 1'b0; reg_ms = 1'b0; reg_ms2 = 1'b0;
    endtask

    // lat = negedges from the call until mem_ack is seen high.
    task automatic pio_wait(input string tag, output logic [31:0] rd, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (cur_ack) begin lat = i; break; end
        end
        chk({tag, "_ack"}, cur_ack, 1'b1);
        rd = cur_rdata;
        for (int i = 0; i < 40; i++) begin
            if (!cur_ack) break;
            @(negedge clk);
        end
    endtask

    task automatic pio(input bit wr, input logic [31:0] addr, input logic [31:0] din,
                       input string tag, input int exp_lat, input bit do_rd, input logic [31:0] exp_rd);
        logic [31:0] rd;
        int lat;
        @(negedge clk);
        pio_issue(wr, addr, din);
        pio_wait(tag, rd, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        if (do_rd) chk({tag, "_data"}, rd, exp_rd);
    endtask

    // Called at a negedge.
    task automatic app_read(input logic [9:0] a, input string tag, input logic [99:0] exp);
        app_mem_rd = 1'b1; app_mem_raddr = a;
        @(negedge clk);
        app_mem_rd = 1'b0;
        chk({tag, "_ack_early"}, app_mem_ack, 1'b0);
        @(negedge clk);
        chk({tag, "_ack"}, app_mem_ack, 1'b1);
        chk({tag, "_data"}, app_mem_rdata, exp);
        @(negedge clk);
        chk({tag, "_ack_drop"}, app_mem_ack, 1'b0);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, hi, trans;
        logic div_e, a0, a1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_mem_ack", mem_ack, 1'b0);
        chk("rst_app_ack", app_mem_ack, 1'b0);
        chk("rst_mem_ack2", mem_ack2, 1'b0);

        // Fill entry 5, read it back over the app port.
        pio(1, 32'h50, 32'h11111111, "wr50", 1, 0, '0);
        pio(1, 32'h54, 32'h22222222, "wr54", 1, 0, '0);
        pio(1, 32'h58, 32'h33333333, "wr58", 1, 0, '0);
        pio(1, 32'h5C, 32'h0000000F, "wr5c", 1, 0, '0);
        @(negedge clk);
        app_read(10'd5, "app5", 100'hF_33333333_22222222_11111111);

        // Commit alone: the staged words from entry 5 are reused, top word truncated.
        pio(1, 32'h6C, 32'hFFFFFFFC, "wr6c", 1, 0, '0);
        @(negedge clk);
        app_read(10'd6, "app6", 100'hC_33333333_22222222_11111111);

        // Word 0 fetches; the rest come from capture.
        pio(0, 32'h50, '0, "rd50", 2, 1, 32'h11111111);
        pio(0, 32'h54, '0, "rd54", 1, 1, 32'h22222222);
        pio(0, 32'h58, '0, "rd58", 1, 1, 32'h33333333);
        pio(0, 32'h5C, '0, "rd5c", 1, 1, 32'h0000000F);

        // Capture is not refreshed by a RAM change.
        @(negedge clk);
        app_mem_wr = 1'b1; app_mem_waddr = 10'd5; app_mem_wdata = 100'h7_77777777_66666666_55555555;
        @(negedge clk);
        app_mem_wr = 1'b0;
        pio(0, 32'h54, '0, "rd54_stale", 1, 1, 32'h22222222);

        // Word-0 read colliding with 3 clks of app reads.
        @(negedge clk);
        app_mem_rd = 1'b1; app_mem_raddr = 10'd6;
        pio_issue(0, 32'h50, '0);
        @(negedge clk);
        @(negedge clk);
        app_mem_rd = 1'b0;
        pio_wait("rd50_coll", rd, lat);
        chk("rd50_coll_lat", lat, 3);
        chk("rd50_coll_data", rd, 32'h55555555);

        // Commit to entry 7 colliding with an app write to entry 7.
        pio(1, 32'h70, 32'h00000001, "wr70", 1, 0, '0);
        pio(1, 32'h74, 32'h00000002, "wr74", 1, 0, '0);
        pio(1, 32'h78, 32'h00000003, "wr78", 1, 0, '0);
        @(negedge clk);
        app_mem_wr = 1'b1; app_mem_waddr = 10'd7; app_mem_wdata = {25{4'hA}};
        pio_issue(1, 32'h7C, 32'h00000005);
        app_mem_wr = 1'b0;
        fork
            begin
                logic [31:0] rd_c;
                int lat_c;
                pio_wait("wr7c_coll", rd_c, lat_c);
                chk("wr7c_coll_lat", lat_c, 2);
            end
            app_read(10'd7, "app7_first", {25{4'hA}});
        join
        @(negedge clk);
        app_read(10'd7, "app7_final", 100'h5_00000003_00000002_00000001);

        // clk_div every 4th clk: mem_ack spans one clk_div period, on its edges.
        div4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); #1;
            if (clk_div) break;
        end
        reg_addr = 32'h80; reg_din = 32'h1234; reg_wr = 1'b1; reg_ms = 1'b1;
        hi = 0; trans = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            div_e = clk_div; a0 = mem_ack;
            #1;
            a1 = mem_ack;
            if (i == 0) begin reg_wr = 1'b0; reg_ms = 1'b0; end
            if (a1 !== a0) begin
                trans++;
                chk("div_align", div_e, 1'b1);
            end
            if (a1) hi++;
        end
        chk("div_ack_clks", hi, 4);
        chk("div_ack_edges", trans, 2);
        div4 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while a commit is parked in wr_pend.
        @(negedge clk);
        app_mem_wr = 1'b1; app_mem_waddr = 10'd9; app_mem_wdata = 100'h9_99999999_88888888_77777777;
        @(negedge clk);
        app_mem_wr = 1'b0;
        pio(1, 32'h90, 32'h000000A1, "wr90", 1, 0, '0);
        pio(1, 32'h94, 32'h000000A2, "wr94", 1, 0, '0);
        pio(1, 32'h98, 32'h000000A3, "wr98", 1, 0, '0);
        @(negedge clk);
        app_mem_wr = 1'b1; app_mem_waddr = 10'd10; app_mem_wdata = 100'h1;
        pio_issue(1, 32'h9C, 32'h0000000B);
        app_mem_wr = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_ack) hi++;
        end
        chk("rst_pend_no_ack", hi, 0);
        app_read(10'd9, "app9_kept", 100'h9_99999999_88888888_77777777);

        // 160-bit instance: word indices 5..7 lie beyond the entry.
        sel2 = 1'b1;
        pio(1, 32'h60, 32'h0A0A0A0A, "d2_wr60", 1, 0, '0);
        pio(1, 32'h64, 32'h1B1B1B1B, "d2_wr64", 1, 0, '0);
        pio(1, 32'h68, 32'h2C2C2C2C, "d2_wr68", 1, 0, '0);
        pio(1, 32'h6C, 32'h3D3D3D3D, "d2_wr6c", 1, 0, '0);
        pio(1, 32'h70, 32'h4E4E4E4E, "d2_wr70", 1, 0, '0);
        pio(1, 32'h74, 32'hDEADBEEF, "d2_wr74_oob", 1, 0, '0);
        pio(0, 32'h60, '0, "d2_rd60", 2, 1, 32'h0A0A0A0A);
        pio(0, 32'h74, '0, "d2_rd74_oob", 1, 1, 32'h0);
        pio(0, 32'h70, '0, "d2_rd70", 1, 1, 32'h4E4E4E4E);
        sel2 = 1'b0;
        @(negedge clk);
        app_mem_rd2 = 1'b1; app_mem_raddr2 = 4'd3;
        @(negedge clk);
        app_mem_rd2 = 1'b0;
        @(negedge clk);
        chk("d2_app_ack", app_mem_ack2, 1'b1);
        chk("d2_app_data", app_mem_rdata2, 160'h4E4E4E4E_3D3D3D3D_2C2C2C2C_1B1B1B1B_0A0A0A0A);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
